// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets up to four requesters write bursts into one FIFO.
// The handshake is combinational: the FIFO captures the owner's word on the edge where it is accepted.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  output logic [1:0]                    owner,
  output logic                          busy,
  output logic                          stall
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_owner, w_owner_next;
  logic [1:0]       r_last_grant, w_last_grant_next;
  logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_next;

  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
  logic [1:0]            w_scan_base;
  logic [1:0]            w_sel_idx;
  logic [1:0]            w_cand;
  logic                  w_sel_found;
  logic                  w_owner_valid;
  logic                  w_transfer;
  logic                  w_last_beat;
  logic                  w_release;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_slice[gi]   = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = w_transfer && (r_owner == 2'(gi));
    end
  endgenerate

  assign w_owner_valid = req_valid[r_owner];
  // Gating with reset keeps the write strobe low for the whole reset pulse.
  assign w_transfer    = (r_state == GRANT) && w_owner_valid && !fifo_full && !reset;
  assign w_last_beat   = (r_burst_cnt == CNT_W'(BURST_LEN - 1));
  assign w_release     = (r_state == GRANT) && ((w_transfer && w_last_beat) || !w_owner_valid);

  assign fifo_write_en = w_transfer;
  assign fifo_data_in  = (r_state == GRANT) ? w_slice[r_owner] : '0;
  assign owner         = r_owner;
  assign busy          = (r_state == GRANT);
  assign stall         = (r_state == GRANT) && w_owner_valid && fifo_full;

  // On release the outgoing owner becomes last_grant, so the scan starts just past it.
  assign w_scan_base = (r_state == GRANT) ? r_owner : r_last_grant;

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = w_scan_base;
    w_cand      = w_scan_base;
    for (int k = 1; k <= 4; k++) begin
      w_cand = w_scan_base + 2'(k);
      if (!w_sel_found && req_valid[w_cand]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_owner_next      = r_owner;
    w_last_grant_next = r_last_grant;
    w_burst_cnt_next  = r_burst_cnt;
    case (r_state)
      IDLE: begin
        if (w_sel_found) begin
          w_state_next     = GRANT;
          w_owner_next     = w_sel_idx;
          w_burst_cnt_next = '0;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_last_grant_next = r_owner;
          w_burst_cnt_next  = '0;
          if (w_sel_found) begin
            w_owner_next = w_sel_idx;
          end else begin
            w_state_next = IDLE;
          end
        end else if (w_transfer) begin
          w_burst_cnt_next = r_burst_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 2'd0;
      r_last_grant <= 2'd3;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_owner      <= w_owner_next;
      r_last_grant <= w_last_grant_next;
      r_burst_cnt  <= w_burst_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: simple requester queues and an 8-deep FIFO occupancy model.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_write_en;
  logic [15:0] fifo_data_in;
  logic        fifo_full;
  logic [1:0]  owner;
  logic        busy;
  logic        stall;

  int   total = 0;
  int   bad   = 0;
  int   rem [4];
  int   cnt [4];
  logic force_full;
  logic use_fifo;
  logic fifo_clr;
  int   fifo_cnt;
  logic fifo_ovf;
  int   rst_writes;

  fifo_write_arbiter #(.DATA_WIDTH(16), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
    .fifo_full(fifo_full), .owner(owner), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  assign fifo_full = use_fifo ? (fifo_cnt == 8) : force_full;

  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_cnt   <= 0;
      fifo_ovf   <= 1'b0;
      rst_writes <= 0;
    end else begin
      if (fifo_write_en) begin
        if (fifo_cnt == 8) fifo_ovf <= 1'b1;
        else fifo_cnt <= fifo_cnt + 1;
      end
      if (reset && fifo_write_en) rst_writes <= rst_writes + 1;
    end
  end

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]          = (rem[i] > 0);
      req_data[i*16 +: 16]  = 16'(i*4096 + cnt[i]);
    end
  endtask

  task automatic consume();
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i] === 1'b1) begin
        rem[i]--;
        cnt[i]++;
      end
    end
  endtask

  task automatic tick(input logic ff);
    @(negedge clk);
    force_full = ff;
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    force_full = 1'b0;
    use_fifo   = 1'b0;
    fifo_clr   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0;
      cnt[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    fifo_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    reset = 1'b1; force_full = 1'b0; use_fifo = 1'b0; fifo_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin rem[i] = 3; cnt[i] = 0; end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive();
      #1;
      obs = {busy, owner, fifo_write_en, stall, req_ready};
      total++;
      if (obs !== 9'b0_00_0_0_0000) begin
        bad++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=%b", c, obs, 9'b0_00_0_0_0000);
      end
      total++;
      if (fifo_data_in !== 16'h0000) begin
        bad++;
        $display("FAIL reset_data cyc=%0d got=%h exp=0000", c, fifo_data_in);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_req();
    logic [8:0] obs, exp;
    do_reset();
    rem[1] = 6;
    for (int c = 0; c <= 7; c++) begin
      tick(1'b0);
      obs = {busy, owner, fifo_write_en, stall, req_ready};
      if (c == 0)      exp = 9'b0_00_0_0_0000;
      else if (c <= 6) exp = 9'b1_01_1_0_0010;
      else             exp = 9'b1_01_0_0_0000;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL single_ctrl cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c >= 1 && c <= 6) begin
        total++;
        if (fifo_data_in !== 16'(16'h1000 + c - 1)) begin
          bad++;
          $display("FAIL single_data cyc=%0d got=%h exp=%h", c, fifo_data_in, 16'(16'h1000 + c - 1));
        end
      end
      $display("single cyc=%0d owner=%0d we=%b data=%h", c, owner, fifo_write_en, fifo_data_in);
      consume();
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] obs, exp;
    logic [1:0] o;
    do_reset();
    for (int i = 0; i < 4; i++) rem[i] = 8;
    for (int c = 0; c <= 16; c++) begin
      tick(1'b0);
      obs = {busy, owner, fifo_write_en, stall, req_ready};
      o   = 2'((c - 1) / 4);
      exp = (c == 0) ? 9'b0_00_0_0_0000 : {1'b1, o, 1'b1, 1'b0, 4'(4'b0001 << o)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL rr_ctrl cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c >= 1) begin
        total++;
        if (fifo_data_in !== 16'(o*4096 + (c - 1) % 4)) begin
          bad++;
          $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, fifo_data_in, 16'(o*4096 + (c - 1) % 4));
        end
      end
      $display("rr cyc=%0d owner=%0d we=%b data=%h", c, owner, fifo_write_en, fifo_data_in);
      consume();
    end
  endtask

  task automatic test_full_stall();
    logic [8:0]  obs, exp;
    logic [15:0] dexp;
    logic        full_now;
    do_reset();
    rem[0] = 6;
    rem[1] = 1;
    for (int c = 0; c <= 8; c++) begin
      full_now = (c >= 3 && c <= 5);
      tick(full_now);
      obs  = {busy, owner, fifo_write_en, stall, req_ready};
      dexp = 16'h0000;
      case (c)
        0:       exp = 9'b0_00_0_0_0000;
        1, 2:    begin exp = 9'b1_00_1_0_0001; dexp = 16'(c - 1); end
        3, 4, 5: exp = 9'b1_00_0_1_0000;
        6, 7:    begin exp = 9'b1_00_1_0_0001; dexp = 16'(c - 4); end
        default: begin exp = 9'b1_01_1_0_0010; dexp = 16'h1000; end
      endcase
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL stall_ctrl cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (exp[5]) begin
        total++;
        if (fifo_data_in !== dexp) begin
          bad++;
          $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, fifo_data_in, dexp);
        end
      end
      $display("stall cyc=%0d full=%b owner=%0d we=%b stall=%b", c, fifo_full, owner, fifo_write_en, stall);
      consume();
    end
  endtask

  task automatic test_owner_drop();
    logic [8:0]  obs, exp;
    logic [15:0] dexp;
    do_reset();
    rem[0] = 2;
    rem[2] = 3;
    for (int c = 0; c <= 5; c++) begin
      tick(1'b0);
      obs  = {busy, owner, fifo_write_en, stall, req_ready};
      dexp = 16'h0000;
      case (c)
        0:       exp = 9'b0_00_0_0_0000;
        1, 2:    begin exp = 9'b1_00_1_0_0001; dexp = 16'(c - 1); end
        3:       exp = 9'b1_00_0_0_0000;
        default: begin exp = 9'b1_10_1_0_0100; dexp = 16'(16'h2000 + c - 4); end
      endcase
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL drop_ctrl cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (exp[5]) begin
        total++;
        if (fifo_data_in !== dexp) begin
          bad++;
          $display("FAIL drop_data cyc=%0d got=%h exp=%h", c, fifo_data_in, dexp);
        end
      end
      $display("drop cyc=%0d owner=%0d we=%b data=%h", c, owner, fifo_write_en, fifo_data_in);
      consume();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [8:0] obs, exp;
    do_reset();
    rem[0] = 8;
    for (int c = 0; c <= 2; c++) begin
      tick(1'b0);
      consume();
    end
    tick(1'b0);
    total++;
    if (fifo_write_en !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre_we got=%b exp=1", fifo_write_en);
    end
    reset = 1'b1;
    #1;
    obs = {busy, owner, fifo_write_en, stall, req_ready};
    total++;
    if (obs !== 9'b0_00_0_0_0000 || fifo_data_in !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_drop got=%b/%h exp=%b/0000", obs, fifo_data_in, 9'b0_00_0_0_0000);
    end
    $display("midrst reset asserted we=%b busy=%b", fifo_write_en, busy);
    rem[0] = 0; rem[1] = 5; rem[3] = 5;
    drive();
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (fifo_write_en !== 1'b0 || rst_writes !== 0) begin
      bad++;
      $display("FAIL midrst_hold we=%b writes=%0d exp=0/0", fifo_write_en, rst_writes);
    end
    reset = 1'b0;
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick(1'b0);
      obs = {busy, owner, fifo_write_en, stall, req_ready};
      exp = (c <= 4) ? 9'b1_01_1_0_0010 : 9'b1_11_1_0_1000;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL midrst_ctrl cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      total++;
      if (fifo_data_in !== ((c <= 4) ? 16'(16'h1000 + c - 1) : 16'h3000)) begin
        bad++;
        $display("FAIL midrst_data cyc=%0d got=%h", c, fifo_data_in);
      end
      $display("midrst cyc=%0d owner=%0d we=%b data=%h", c, owner, fifo_write_en, fifo_data_in);
      consume();
    end
  endtask

  task automatic test_fifo_fill();
    logic [3:0] obs, exp;
    do_reset();
    use_fifo = 1'b1;
    for (int i = 0; i < 4; i++) rem[i] = 8;
    for (int c = 0; c <= 13; c++) begin
      tick(1'b0);
      obs = {busy, fifo_write_en, stall, fifo_full};
      if (c == 0)      exp = 4'b0000;
      else if (c <= 8) exp = 4'b1100;
      else             exp = 4'b1011;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL fill_ctrl cyc=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c >= 9) begin
        total++;
        if (owner !== 2'd2) begin
          bad++;
          $display("FAIL fill_owner cyc=%0d got=%0d exp=2", c, owner);
        end
      end
      $display("fill cyc=%0d count=%0d we=%b stall=%b", c, fifo_cnt, fifo_write_en, stall);
      consume();
    end
    total++;
    if (fifo_cnt !== 8 || fifo_ovf !== 1'b0) begin
      bad++;
      $display("FAIL fill_final count=%0d ovf=%b exp=8/0", fifo_cnt, fifo_ovf);
    end
  endtask

  initial begin
    reset      = 1'b1;
    force_full = 1'b0;
    use_fifo   = 1'b0;
    fifo_clr   = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    test_reset();
    test_single_req();
    test_round_robin();
    test_full_stall();
    test_owner_drop();
    test_reset_mid_burst();
    test_fifo_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
